id_ex_pipe_chain: RTL and testbench
===================================

// Module: id_ex_pipe_chain
// PURPOSE
//  Parametrised ID->EX pipeline register chain, DEPTH stages deep, each stage holding
//  control word, opcode, three operands and two register indices plus a valid bit.
//  Adds what a single-stage register lacks: bubble insertion (in_valid=0) and a flush
//  that kills all in-flight slots. Also provides an occupancy count and a
//  destination-register hazard lookup across all in-flight stages.
//  Sits between decode and execute; DEPTH>1 models a deeper front end / multi-cycle issue.
// PARAMETERS
//  DEPTH      2   number of register stages (>=1)
//  DATA_W     16  width of src1/read1/src2 operands
//  CTRL_W     16  width of control word
//  OP_W       4   opcode width
//  REG_W      4   register index width (rd, rt)
//  WB_BIT     0   index in control word meaning "writes rd"
//  ZERO_EXEMPT 1  1: query_reg==0 never reports a hazard
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rest       in   1       synchronous active-high reset
//  freeze     in   1       hold all stages (stall)
//  flush      in   1       invalidate all stages
//  in_valid   in   1       1: inputs carry an instruction; 0: insert bubble
//  ctrl_in    in   CTRL_W  control word
//  opcode_in  in   OP_W    opcode
//  src1_in    in   DATA_W  operand 1
//  read1_in   in   DATA_W  register read value 1
//  src2_in    in   DATA_W  operand 2
//  rd_in      in   REG_W   destination register
//  rt_in      in   REG_W   second register index
//  out_valid  out  1       last stage holds a valid instruction
//  ctrl_out .. rt_out  out  (same widths)  last-stage fields
//  occupancy  out  $clog2(DEPTH+1)  count of valid stages
//  query_reg  in   REG_W   register to check for pending write
//  hazard_hit out  1       some valid stage will write query_reg
// BEHAVIOUR
//  - Priority per edge: rest > flush > freeze > advance.
//  - rest: every stage valid=0, all fields 0. All outputs 0 the cycle after rest.
//  - flush (rest=0): all valid=0, all fields 0, even when freeze=1.
//  - freeze (rest=0, flush=0): no stage changes; inputs are dropped.
//  - advance: stage k <= stage k-1 (k>=1); stage 0 <= inputs with valid=in_valid.
//    If in_valid=0, stage 0 loads valid=0 and all fields 0 (clean bubble).
//  - Latency: instruction accepted at edge N appears on outputs after edge N+DEPTH-1,
//    i.e. DEPTH cycles from input presentation, given no freeze in between.
//  - Outputs driven directly from last-stage registers; an invalid last stage always
//    reads as all-zero fields (bubbles and flush guarantee this).
//  - occupancy: registered-state popcount of valid bits, 0..DEPTH, combinational from
//    state; updates in the same cycle as the stage contents.
//  - hazard_hit: combinational OR over stages of valid & ctrl[WB_BIT] & (rd==query_reg);
//    forced 0 when ZERO_EXEMPT=1 and query_reg==0. Reflects current state only, not
//    the instruction on the inputs.
//  - DEPTH=1 reduces to a single-stage register with bubble/flush.
//  - No overflow: the chain is a fixed shift; the last-stage slot is overwritten on
//    advance whether or not it was valid (downstream has no back-pressure).
// TESTING
//  1 rest=1 two cycles with random inputs -> all outputs 0, occupancy=0, hazard_hit=0.
//  2 DEPTH=2: in_valid=1, ctrl=16'h0001, rd=4'h5, src1=16'hABCD at edge 0, bubbles after
//    -> out_valid=1, src1_out=ABCD after edge 1; occupancy 1,1,0 after edges 0,1,2.
//  3 Same instr, query_reg=5 -> hazard_hit=1 after edges 0 and 1, 0 after edge 2;
//    query_reg=0 with rd=0 and ZERO_EXEMPT=1 -> hazard_hit=0.
//  4 Fill both stages, freeze=1 three cycles with new inputs -> outputs/occupancy
//    unchanged, new inputs never appear.
//  5 Fill both stages, freeze=1 and flush=1 same cycle -> occupancy=0, out_valid=0,
//    fields 0 next cycle.
//  6 Stream 4 back-to-back instrs, rest=1 mid-stream -> all cleared; resumed stream
//    exits in order with DEPTH-cycle latency.

Source files
------------

// File: rtl/id_ex_pipe_chain_if.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_chain_if
//   Instruction bus between decode and execute. The in_* group carries one
//   decoded instruction into the pipe chain; the out_* group presents the
//   oldest in-flight slot to execute.
//   master : decode-side producer / execute-side consumer (drives in_*)
//   slave  : the pipe chain (drives out_*)
// ---------------------------------------------------------------------------
interface id_ex_pipe_chain_if #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 16,
  parameter int OP_W   = 4,
  parameter int REG_W  = 4
);
  logic              in_valid;
  logic [CTRL_W-1:0] ctrl_in;
  logic [OP_W-1:0]   opcode_in;
  logic [DATA_W-1:0] src1_in;
  logic [DATA_W-1:0] read1_in;
  logic [DATA_W-1:0] src2_in;
  logic [REG_W-1:0]  rd_in;
  logic [REG_W-1:0]  rt_in;

  logic              out_valid;
  logic [CTRL_W-1:0] ctrl_out;
  logic [OP_W-1:0]   opcode_out;
  logic [DATA_W-1:0] src1_out;
  logic [DATA_W-1:0] read1_out;
  logic [DATA_W-1:0] src2_out;
  logic [REG_W-1:0]  rd_out;
  logic [REG_W-1:0]  rt_out;

  modport master (
    output in_valid, ctrl_in, opcode_in, src1_in, read1_in, src2_in, rd_in, rt_in,
    input  out_valid, ctrl_out, opcode_out, src1_out, read1_out, src2_out, rd_out, rt_out
  );

  modport slave (
    input  in_valid, ctrl_in, opcode_in, src1_in, read1_in, src2_in, rd_in, rt_in,
    output out_valid, ctrl_out, opcode_out, src1_out, read1_out, src2_out, rd_out, rt_out
  );
endinterface

// File: rtl/id_ex_pipe_chain.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_chain
//   DEPTH-stage ID->EX register chain with bubble insertion, flush, occupancy
//   count and a destination-register hazard lookup over all in-flight slots.
// Ports
//   clk        clock, all state on rising edge
//   rest       synchronous active-high reset
//   freeze     hold every stage, drop the inputs
//   flush      invalidate every stage (wins over freeze)
//   bus        instruction in / last-stage instruction out (slave modport)
//   query_reg  register index to look up
//   occupancy  number of valid stages, from registered state
//   hazard_hit some valid stage has the write-back bit set and rd==query_reg
// ---------------------------------------------------------------------------
module id_ex_pipe_chain #(
  parameter int DEPTH       = 2,
  parameter int DATA_W      = 16,
  parameter int CTRL_W      = 16,
  parameter int OP_W        = 4,
  parameter int REG_W       = 4,
  parameter int WB_BIT      = 0,
  parameter int ZERO_EXEMPT = 1
) (
  input  logic                       clk,
  input  logic                       rest,
  input  logic                       freeze,
  input  logic                       flush,
  id_ex_pipe_chain_if.slave          bus,
  input  logic [REG_W-1:0]           query_reg,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       hazard_hit
);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  vld_q;
  logic [CTRL_W-1:0] ctrl_q  [DEPTH];
  logic [OP_W-1:0]   op_q    [DEPTH];
  logic [DATA_W-1:0] src1_q  [DEPTH];
  logic [DATA_W-1:0] read1_q [DEPTH];
  logic [DATA_W-1:0] src2_q  [DEPTH];
  logic [REG_W-1:0]  rd_q    [DEPTH];
  logic [REG_W-1:0]  rt_q    [DEPTH];

  always_ff @(posedge clk) begin
    if (rest || flush) begin
      // Fields are zeroed too, so an invalid last stage always reads as zero.
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        ctrl_q[k]  <= '0;
        op_q[k]    <= '0;
        src1_q[k]  <= '0;
        read1_q[k] <= '0;
        src2_q[k]  <= '0;
        rd_q[k]    <= '0;
        rt_q[k]    <= '0;
      end
    end else if (!freeze) begin
      for (int k = 1; k < DEPTH; k++) begin
        vld_q[k]   <= vld_q[k-1];
        ctrl_q[k]  <= ctrl_q[k-1];
        op_q[k]    <= op_q[k-1];
        src1_q[k]  <= src1_q[k-1];
        read1_q[k] <= read1_q[k-1];
        src2_q[k]  <= src2_q[k-1];
        rd_q[k]    <= rd_q[k-1];
        rt_q[k]    <= rt_q[k-1];
      end
      // A bubble enters as all-zero fields, not just a cleared valid bit.
      vld_q[0] <= bus.in_valid;
      if (bus.in_valid) begin
        ctrl_q[0]  <= bus.ctrl_in;
        op_q[0]    <= bus.opcode_in;
        src1_q[0]  <= bus.src1_in;
        read1_q[0] <= bus.read1_in;
        src2_q[0]  <= bus.src2_in;
        rd_q[0]    <= bus.rd_in;
        rt_q[0]    <= bus.rt_in;
      end else begin
        ctrl_q[0]  <= '0;
        op_q[0]    <= '0;
        src1_q[0]  <= '0;
        read1_q[0] <= '0;
        src2_q[0]  <= '0;
        rd_q[0]    <= '0;
        rt_q[0]    <= '0;
      end
    end
  end

  assign bus.out_valid  = vld_q[DEPTH-1];
  assign bus.ctrl_out   = ctrl_q[DEPTH-1];
  assign bus.opcode_out = op_q[DEPTH-1];
  assign bus.src1_out   = src1_q[DEPTH-1];
  assign bus.read1_out  = read1_q[DEPTH-1];
  assign bus.src2_out   = src2_q[DEPTH-1];
  assign bus.rd_out     = rd_q[DEPTH-1];
  assign bus.rt_out     = rt_q[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + OCC_W'(vld_q[k]);
    end
  end

  // Looks only at registered stages; the instruction on the inputs is not
  // yet in flight and is deliberately excluded.
  always_comb begin
    hazard_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (vld_q[k] && ctrl_q[k][WB_BIT] && (rd_q[k] == query_reg)) begin
        hazard_hit = 1'b1;
      end
    end
    if ((ZERO_EXEMPT != 0) && (query_reg == '0)) begin
      hazard_hit = 1'b0;
    end
  end
endmodule

// File: tb/tb_id_ex_pipe_chain.sv
module tb_id_ex_pipe_chain;
  localparam int DEPTH       = 2;
  localparam int DATA_W      = 16;
  localparam int CTRL_W      = 16;
  localparam int OP_W        = 4;
  localparam int REG_W       = 4;
  localparam int WB_BIT      = 0;
  localparam int ZERO_EXEMPT = 1;
  localparam int OCC_W       = $clog2(DEPTH+1);

  typedef struct packed {
    logic              v;
    logic [CTRL_W-1:0] ctrl;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] s2;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rt;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rest, flush, freeze;
  logic [REG_W-1:0] query_reg;
  logic [OCC_W-1:0] occupancy;
  logic             hazard_hit;

  id_ex_pipe_chain_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .OP_W(OP_W), .REG_W(REG_W)) bus ();

  id_ex_pipe_chain #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .OP_W(OP_W),
    .REG_W(REG_W), .WB_BIT(WB_BIT), .ZERO_EXEMPT(ZERO_EXEMPT)
  ) dut (
    .clk(clk), .rest(rest), .freeze(freeze), .flush(flush), .bus(bus),
    .query_reg(query_reg), .occupancy(occupancy), .hazard_hit(hazard_hit)
  );

  // Reference model: slots[0] youngest .. slots[DEPTH-1] oldest (visible on outputs).
  // exp_q holds issued instructions still in flight, oldest first.
  txn_t slots[$];
  txn_t exp_q[$];
  int   evt = 2;          // what the coming edge does: 0 advance, 1 freeze, 2 clear
  bit   mon_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_occ();
    int n = 0;
    foreach (slots[i]) if (slots[i].v) n++;
    return n;
  endfunction

  function automatic logic model_haz(input logic [REG_W-1:0] q);
    if (ZERO_EXEMPT != 0 && q == 0) return 1'b0;
    foreach (slots[i])
      if (slots[i].v && slots[i].ctrl[WB_BIT] && slots[i].rd == q) return 1'b1;
    return 1'b0;
  endfunction

  function automatic txn_t rand_txn(input bit v);
    txn_t t;
    t.v    = v;
    t.ctrl = CTRL_W'($urandom);
    t.op   = OP_W'($urandom);
    t.s1   = DATA_W'($urandom);
    t.r1   = DATA_W'($urandom);
    t.s2   = DATA_W'($urandom);
    t.rd   = REG_W'($urandom_range(0, 15));
    t.rt   = REG_W'($urandom);
    return t;
  endfunction

  // Drive inputs for the coming edge and advance the model to its post-edge state.
  task automatic apply(input bit r, input bit fl, input bit fr, input txn_t t,
                       input logic [REG_W-1:0] q);
    txn_t nw;
    rest = r; flush = fl; freeze = fr; query_reg = q;
    bus.in_valid  = t.v;       bus.ctrl_in  = t.ctrl; bus.opcode_in = t.op;
    bus.src1_in   = t.s1;      bus.read1_in = t.r1;   bus.src2_in   = t.s2;
    bus.rd_in     = t.rd;      bus.rt_in    = t.rt;
    if (r || fl) begin
      slots.delete();
      for (int i = 0; i < DEPTH; i++) slots.push_back('0);
      exp_q.delete();
      evt = 2;
    end else if (fr) begin
      evt = 1;
    end else begin
      nw = t.v ? t : '0;
      slots.push_front(nw);
      void'(slots.pop_back());
      if (t.v) exp_q.push_back(nw);
      evt = 0;
    end
  endtask

  task automatic step(input bit r, input bit fl, input bit fr, input txn_t t,
                      input logic [REG_W-1:0] q);
    @(negedge clk);
    apply(r, fl, fr, t, q);
  endtask

  // Monitor: after each edge, retire what the model says reached the last stage
  // and compare every DUT output.
  txn_t cur = '0;
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (evt == 2) begin
        cur = '0;
      end else if (evt == 0) begin
        if (slots[DEPTH-1].v) begin
          if (exp_q.size() == 0) begin
            chk("exp_q_underflow", 64'd1, 64'd0);
            cur = '0;
          end else begin
            cur = exp_q.pop_front();
          end
        end else begin
          cur = '0;
        end
      end
      chk("out_valid",  64'(bus.out_valid),  64'(cur.v));
      chk("ctrl_out",   64'(bus.ctrl_out),   64'(cur.ctrl));
      chk("opcode_out", 64'(bus.opcode_out), 64'(cur.op));
      chk("src1_out",   64'(bus.src1_out),   64'(cur.s1));
      chk("read1_out",  64'(bus.read1_out),  64'(cur.r1));
      chk("src2_out",   64'(bus.src2_out),   64'(cur.s2));
      chk("rd_out",     64'(bus.rd_out),     64'(cur.rd));
      chk("rt_out",     64'(bus.rt_out),     64'(cur.rt));
      chk("occupancy",  64'(occupancy),      64'(model_occ()));
      chk("hazard_hit", 64'(hazard_hit),     64'(model_haz(query_reg)));
    end
  end

  initial begin
    txn_t t;
    for (int i = 0; i < DEPTH; i++) slots.push_back('0);

    // Reset two cycles with random inputs.
    apply(1'b1, 1'b0, 1'b0, rand_txn(1'b1), REG_W'($urandom));
    mon_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, rand_txn(1'b1), REG_W'($urandom));

    // Single instruction, rd=5 with write-back, followed by bubbles; query 5.
    t = rand_txn(1'b1);
    t.ctrl = 16'h0001; t.rd = 4'h5; t.s1 = 16'hABCD;
    step(1'b0, 1'b0, 1'b0, t, 4'h5);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, rand_txn(1'b0), 4'h5);

    // rd=0 write-back with query 0 must never report a hazard.
    t = rand_txn(1'b1);
    t.ctrl = 16'h0001; t.rd = 4'h0;
    step(1'b0, 1'b0, 1'b0, t, 4'h0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, rand_txn(1'b0), 4'h0);

    // Fill, then freeze three cycles with new inputs, then drain.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b0, rand_txn(1'b1), REG_W'($urandom));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, rand_txn(1'b1), REG_W'($urandom));
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b0, 1'b0, rand_txn(1'b0), REG_W'($urandom));

    // Fill, then freeze and flush together.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b0, rand_txn(1'b1), REG_W'($urandom));
    step(1'b0, 1'b1, 1'b1, rand_txn(1'b1), REG_W'($urandom));
    step(1'b0, 1'b0, 1'b0, rand_txn(1'b0), REG_W'($urandom));

    // Back-to-back stream with reset mid-stream, then resume.
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, rand_txn(1'b1), REG_W'($urandom));
    step(1'b1, 1'b0, 1'b0, rand_txn(1'b1), REG_W'($urandom));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, rand_txn(1'b1), REG_W'($urandom));
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b0, rand_txn(1'b0), REG_W'($urandom));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit r, fl, fr, v;
      r  = ($urandom_range(0, 99) < 3);
      fl = ($urandom_range(0, 99) < 5);
      fr = ($urandom_range(0, 99) < 20);
      v  = ($urandom_range(0, 99) < 70);
      step(r, fl, fr, rand_txn(v), REG_W'($urandom));
    end

    // Drain; every issued instruction must have retired.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b0, rand_txn(1'b0), REG_W'($urandom));
    @(posedge clk);
    #2;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
